// File: rtl/drbg_pkg.sv
// Shared definitions for the DRBG line-key scheduler slice.
//   DRBG_WORD_W  : width of one DRBG output word
//   drbg_state_e : request/fetch FSM states
package drbg_pkg;

    localparam int DRBG_WORD_W = 256;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_FILL = 3'd2,
        S_WAIT = 3'd3,
        S_SEED = 3'd4
    } drbg_state_e;

endpackage

// File: rtl/drbg_word_pingpong.sv
// Two-entry word buffer: one "current" word being sliced into keys and one
// prefetched word waiting to be promoted.
//   clk, rst_n    : clock, asynchronous active-low reset
//   frame_retire  : drop the current word before slicing (frame realign)
//   line_retire   : drop the current word after its last slice was taken
//   wr_en/wr_data : capture a freshly fetched DRBG word
//   idx           : slice index into the (post frame-retire) current word
//   cur_valid     : current word present (as seen after frame_retire)
//   cur_slice     : current_word[idx*KEY_WIDTH +: KEY_WIDTH]
//   any_empty     : at least one slot free (registered view)
module drbg_word_pingpong
    import drbg_pkg::*;
#(
    parameter int KEY_WIDTH = 16,
    parameter int IDX_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_retire,
    input  logic                   line_retire,
    input  logic                   wr_en,
    input  logic [DRBG_WORD_W-1:0] wr_data,
    input  logic [IDX_W-1:0]       idx,
    output logic                   cur_valid,
    output logic [KEY_WIDTH-1:0]   cur_slice,
    output logic                   any_empty
);

    logic [DRBG_WORD_W-1:0] buf_r [0:1];
    logic [1:0]             valid_r;
    logic                   cur_sel_r;

    logic                   sel1_s;
    logic [1:0]             valid1_s;
    logic                   sel2_s;
    logic [1:0]             valid2_s;
    logic                   wr_sel_s;
    logic [1:0]             valid_n_s;
    logic [DRBG_WORD_W-1:0] word_shift_s;

    assign any_empty = ~(&valid_r);

    // Stage 1: apply a frame retire, then expose the resulting current slice.
    always_comb begin
        sel1_s   = cur_sel_r;
        valid1_s = valid_r;
        if (frame_retire && valid_r[cur_sel_r]) begin
            valid1_s[cur_sel_r] = 1'b0;
            sel1_s              = ~cur_sel_r;
        end else begin
            sel1_s   = cur_sel_r;
            valid1_s = valid_r;
        end
        cur_valid    = valid1_s[sel1_s];
        word_shift_s = buf_r[sel1_s] >> (KEY_WIDTH * int'(idx));
        cur_slice    = word_shift_s[KEY_WIDTH-1:0];
    end

    // Stage 2: apply a line retire, then place any captured word. The write
    // target is picked after both retires, so a capture landing in the same
    // cycle as a promotion fills the slot just freed and nothing is lost.
    always_comb begin
        sel2_s   = sel1_s;
        valid2_s = valid1_s;
        if (line_retire && valid1_s[sel1_s]) begin
            valid2_s[sel1_s] = 1'b0;
            sel2_s           = ~sel1_s;
        end else begin
            sel2_s   = sel1_s;
            valid2_s = valid1_s;
        end
        wr_sel_s  = valid2_s[sel2_s] ? ~sel2_s : sel2_s;
        valid_n_s = valid2_s;
        if (wr_en) begin
            valid_n_s[wr_sel_s] = 1'b1;
        end else begin
            valid_n_s = valid2_s;
        end
    end

    // Buffer storage, valid flags and current-slot pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_r[0]  <= {DRBG_WORD_W{1'b0}};
            buf_r[1]  <= {DRBG_WORD_W{1'b0}};
            valid_r   <= 2'b00;
            cur_sel_r <= 1'b0;
        end else begin
            valid_r   <= valid_n_s;
            cur_sel_r <= sel2_s;
            if (wr_en) begin
                buf_r[wr_sel_s] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/drbg_line_key_scheduler.sv
// Consumer side of the DRBG init/next_bits/next_seed handshake. Fetches
// 256-bit words into a ping-pong buffer and hands one KEY_WIDTH slice per
// video line to the scrambler.
//   clk, reset_n            : clock, asynchronous active-low reset
//   enable                  : allows init/fetch activity
//   frame_start, line_start : video strobes (realign / request one key)
//   drbg_init / _ready      : init request and completion level
//   drbg_next_bits / _ready : word request and word-valid level
//   drbg_next_seed          : one-cycle reseed pulse every BITS_PER_SEED words
//   drbg_random_bits        : DRBG output word
//   key, key_valid          : line key and its one-cycle update strobe
//   underrun                : sticky, key requested with no word buffered
//   words_fetched           : captured word count (wraps)
module drbg_line_key_scheduler
    import drbg_pkg::*;
#(
    parameter int KEY_WIDTH     = 16,
    parameter int BITS_PER_SEED = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   frame_start,
    input  logic                   line_start,
    output logic                   drbg_init,
    input  logic                   drbg_init_ready,
    output logic                   drbg_next_bits,
    input  logic                   drbg_next_bits_ready,
    output logic                   drbg_next_seed,
    input  logic [DRBG_WORD_W-1:0] drbg_random_bits,
    output logic [KEY_WIDTH-1:0]   key,
    output logic                   key_valid,
    output logic                   underrun,
    output logic [31:0]            words_fetched
);

    localparam int SLICES = DRBG_WORD_W / KEY_WIDTH;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int SEED_W = (BITS_PER_SEED > 1) ? $clog2(BITS_PER_SEED) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(SLICES - 1);
    localparam logic [SEED_W-1:0] LAST_SEED = SEED_W'(BITS_PER_SEED - 1);

    drbg_state_e            state_r, state_n_s;
    logic                   init_done_r, init_done_n_s;
    logic                   init_rdy_d_r, bits_rdy_d_r;
    logic                   init_rise_s, bits_rise_s;
    logic [31:0]            wf_r, wf_n_s;
    logic [SEED_W-1:0]      seed_cnt_r, seed_cnt_n_s;
    logic                   wr_en_s;

    logic [IDX_W-1:0]       idx_r, idx_n_s, idx_base_s;
    logic                   line_ok_s, line_retire_s;
    logic                   cur_valid_s, any_empty_s;
    logic [KEY_WIDTH-1:0]   cur_slice_s;

    logic                   drbg_init_r, drbg_next_bits_r, drbg_next_seed_r;
    logic [KEY_WIDTH-1:0]   key_r;
    logic                   key_valid_r, underrun_r;

    assign init_rise_s = drbg_init_ready & ~init_rdy_d_r;
    assign bits_rise_s = drbg_next_bits_ready & ~bits_rdy_d_r;

    // A frame strobe restarts slicing at 0 before the same-cycle line strobe.
    assign idx_base_s = frame_start ? {IDX_W{1'b0}} : idx_r;

    drbg_word_pingpong #(
        .KEY_WIDTH (KEY_WIDTH),
        .IDX_W     (IDX_W)
    ) u_pingpong (
        .clk          (clk),
        .rst_n        (reset_n),
        .frame_retire (frame_start),
        .line_retire  (line_retire_s),
        .wr_en        (wr_en_s),
        .wr_data      (drbg_random_bits),
        .idx          (idx_base_s),
        .cur_valid    (cur_valid_s),
        .cur_slice    (cur_slice_s),
        .any_empty    (any_empty_s)
    );

    // Previous-cycle ready levels for rise detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_rdy_d_r <= 1'b0;
            bits_rdy_d_r <= 1'b0;
        end else begin
            init_rdy_d_r <= drbg_init_ready;
            bits_rdy_d_r <= drbg_next_bits_ready;
        end
    end

    // Request FSM next-state, capture and counter updates.
    always_comb begin
        state_n_s     = state_r;
        init_done_n_s = init_done_r;
        wf_n_s        = wf_r;
        seed_cnt_n_s  = seed_cnt_r;
        wr_en_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                // Never raise init while a stale ready is still high.
                if (enable && !init_done_r) begin
                    if (!drbg_init_ready) begin
                        state_n_s = S_INIT;
                    end else begin
                        state_n_s = S_IDLE;
                    end
                end else if (enable) begin
                    state_n_s = S_FILL;
                end else begin
                    state_n_s = S_IDLE;
                end
            end
            S_INIT: begin
                if (init_rise_s) begin
                    init_done_n_s = 1'b1;
                    state_n_s     = S_FILL;
                end else begin
                    state_n_s = S_INIT;
                end
            end
            S_FILL: begin
                if (!enable) begin
                    state_n_s = S_IDLE;
                end else if (any_empty_s && !drbg_next_bits_ready) begin
                    state_n_s = S_WAIT;
                end else begin
                    state_n_s = S_FILL;
                end
            end
            S_WAIT: begin
                // Enable is ignored here so an open handshake always completes.
                if (bits_rise_s) begin
                    wr_en_s = 1'b1;
                    wf_n_s  = wf_r + 32'd1;
                    if (seed_cnt_r == LAST_SEED) begin
                        seed_cnt_n_s = {SEED_W{1'b0}};
                        state_n_s    = S_SEED;
                    end else begin
                        seed_cnt_n_s = seed_cnt_r + SEED_W'(1'b1);
                        state_n_s    = S_FILL;
                    end
                end else begin
                    state_n_s = S_WAIT;
                end
            end
            S_SEED: begin
                state_n_s = S_FILL;
            end
            default: begin
                state_n_s = S_IDLE;
            end
        endcase
    end

    // Slice index advance and word retirement on accepted line strobes.
    always_comb begin
        line_ok_s     = line_start & cur_valid_s;
        line_retire_s = 1'b0;
        idx_n_s       = idx_base_s;
        if (line_ok_s) begin
            if (idx_base_s == LAST_IDX) begin
                idx_n_s       = {IDX_W{1'b0}};
                line_retire_s = 1'b1;
            end else begin
                idx_n_s = idx_base_s + IDX_W'(1'b1);
            end
        end else begin
            idx_n_s = idx_base_s;
        end
    end

    // FSM state, init flag, counters and slice index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= S_IDLE;
            init_done_r <= 1'b0;
            wf_r        <= 32'd0;
            seed_cnt_r  <= {SEED_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
        end else begin
            state_r     <= state_n_s;
            init_done_r <= init_done_n_s;
            wf_r        <= wf_n_s;
            seed_cnt_r  <= seed_cnt_n_s;
            idx_r       <= idx_n_s;
        end
    end

    // Registered handshake outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drbg_init_r      <= 1'b0;
            drbg_next_bits_r <= 1'b0;
            drbg_next_seed_r <= 1'b0;
        end else begin
            drbg_init_r      <= (state_n_s == S_INIT);
            drbg_next_bits_r <= (state_n_s == S_WAIT);
            drbg_next_seed_r <= (state_n_s == S_SEED);
        end
    end

    // Key output, its strobe and the sticky underrun flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_r       <= {KEY_WIDTH{1'b0}};
            key_valid_r <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            key_valid_r <= line_ok_s;
            underrun_r  <= underrun_r | (line_start & ~cur_valid_s);
            if (line_ok_s) begin
                key_r <= cur_slice_s;
            end
        end
    end

    assign drbg_init      = drbg_init_r;
    assign drbg_next_bits = drbg_next_bits_r;
    assign drbg_next_seed = drbg_next_seed_r;
    assign key            = key_r;
    assign key_valid      = key_valid_r;
    assign underrun       = underrun_r;
    assign words_fetched  = wf_r;

endmodule

// File: tb/tb_drbg_line_key_scheduler.sv
// Directed bench for drbg_line_key_scheduler (KEY_WIDTH=64, BITS_PER_SEED=3)
// with a behavioural DRBG that answers each request 3 cycles later.
module tb_drbg_line_key_scheduler;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic         frame_start = 1'b0;
    logic         line_start = 1'b0;
    logic         drbg_init;
    logic         init_ready = 1'b0;
    logic         drbg_next_bits;
    logic         bits_ready = 1'b0;
    logic         drbg_next_seed;
    logic [255:0] rbits = 256'd0;
    logic [63:0]  key;
    logic         key_valid;
    logic         underrun;
    logic [31:0]  words_fetched;

    int checks = 0;
    int errors = 0;

    // DRBG model state
    int   icnt = 0;
    int   bcnt = 0;
    int   word_k = 0;
    logic bits_stall = 1'b0;

    // monitors
    int   init_pulses = 0;
    int   seed_pulses = 0;
    int   seed_wide = 0;
    int   proto_viol = 0;
    logic prev_init = 1'b0;
    logic prev_bits = 1'b0;
    logic prev_seed = 1'b0;

    // consumption reference
    int          cur_k = 0;
    int          cur_s = 0;
    logic [63:0] last_key = 64'd0;

    always #5 clk = ~clk;

    drbg_line_key_scheduler #(
        .KEY_WIDTH     (64),
        .BITS_PER_SEED (3)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .enable               (enable),
        .frame_start          (frame_start),
        .line_start           (line_start),
        .drbg_init            (drbg_init),
        .drbg_init_ready      (init_ready),
        .drbg_next_bits       (drbg_next_bits),
        .drbg_next_bits_ready (bits_ready),
        .drbg_next_seed       (drbg_next_seed),
        .drbg_random_bits     (rbits),
        .key                  (key),
        .key_valid            (key_valid),
        .underrun             (underrun),
        .words_fetched        (words_fetched)
    );

    // Word k: sixteen 16-bit fields, field j = 16*k + j.
    function automatic logic [255:0] make_word(input int k);
        logic [255:0] w;
        for (int j = 0; j < 16; j++) begin
            w[16*j +: 16] = 16'(k * 16 + j);
        end
        return w;
    endfunction

    // DRBG init responder: ready 3 cycles after request, drops with request.
    always @(posedge clk) begin
        if (!drbg_init) begin
            icnt       <= 0;
            init_ready <= 1'b0;
        end else if (!init_ready) begin
            if (icnt == 2) init_ready <= 1'b1;
            icnt <= icnt + 1;
        end
    end

    // DRBG bits responder: presents word word_k with its ready rise.
    always @(posedge clk) begin
        if (!drbg_next_bits) begin
            bcnt       <= 0;
            bits_ready <= 1'b0;
        end else if (!bits_ready && !bits_stall) begin
            if (bcnt == 2) begin
                bits_ready <= 1'b1;
                rbits      <= make_word(word_k);
                word_k     <= word_k + 1;
            end
            bcnt <= bcnt + 1;
        end
    end

    // Handshake monitors sampled away from the active edge.
    always @(negedge clk) begin
        if (drbg_init && !prev_init) init_pulses <= init_pulses + 1;
        if (drbg_next_seed) seed_pulses <= seed_pulses + 1;
        if (drbg_next_seed && prev_seed) seed_wide <= seed_wide + 1;
        if ((drbg_next_bits && !prev_bits && bits_ready) ||
            (drbg_init && !prev_init && init_ready)) proto_viol <= proto_viol + 1;
        prev_init <= drbg_init;
        prev_bits <= drbg_next_bits;
        prev_seed <= drbg_next_seed;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare key against the reference slice and advance the reference.
    task automatic expect_key(input string tag);
        logic [255:0] w;
        logic [63:0]  exp_key;
        w       = make_word(cur_k);
        exp_key = w[64*cur_s +: 64];
        check_eq({tag, "_vld"}, {63'd0, key_valid}, 64'd1);
        check_eq(tag, key, exp_key);
        last_key = exp_key;
        cur_s++;
        if (cur_s == 4) begin
            cur_s = 0;
            cur_k++;
        end
    endtask

    task automatic do_line(input logic frame, input string tag);
        @(negedge clk);
        line_start  = 1'b1;
        frame_start = frame;
        @(negedge clk);
        line_start  = 1'b0;
        frame_start = 1'b0;
        expect_key(tag);
        tick(8);
    endtask

    task automatic wait_wf(input logic [31:0] target, input string tag);
        for (int i = 0; i < 300; i++) begin
            if (words_fetched == target) break;
            @(negedge clk);
        end
        check_eq(tag, {32'd0, words_fetched}, {32'd0, target});
    endtask

    task automatic wait_bits_req(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (drbg_next_bits) break;
            @(negedge clk);
        end
        check_eq(tag, {63'd0, drbg_next_bits}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        // 1. reset state, init, two prefetches
        tick(3);
        check_eq("rst_init", {63'd0, drbg_init}, 64'd0);
        check_eq("rst_bits", {63'd0, drbg_next_bits}, 64'd0);
        check_eq("rst_seed", {63'd0, drbg_next_seed}, 64'd0);
        check_eq("rst_key", key, 64'd0);
        check_eq("rst_kvld", {63'd0, key_valid}, 64'd0);
        check_eq("rst_undr", {63'd0, underrun}, 64'd0);
        check_eq("rst_wf", {32'd0, words_fetched}, 64'd0);
        reset_n = 1'b1;
        enable  = 1'b1;
        wait_wf(32'd2, "t1_wf2");
        tick(15);
        check_eq("t1_wf_stable", {32'd0, words_fetched}, 64'd2);
        check_eq("t1_init_once", 64'(init_pulses), 64'd1);
        check_eq("t1_no_seed", 64'(seed_pulses), 64'd0);
        check_eq("t1_init_low", {63'd0, drbg_init}, 64'd0);

        // 2. four slices of W0 then W1 slice 0
        for (int i = 0; i < 5; i++) do_line(1'b0, $sformatf("t2_key%0d", i));

        // 3. reseed after 3rd and 6th word
        wait_wf(32'd3, "t3_wf3");
        tick(4);
        check_eq("t3_seed1", 64'(seed_pulses), 64'd1);
        check_eq("t3_seed_w", 64'(seed_wide), 64'd0);
        for (int i = 0; i < 11; i++) do_line(1'b0, $sformatf("t3_key%0d", i));
        wait_wf(32'd6, "t3_wf6");
        tick(4);
        check_eq("t3_seed2", 64'(seed_pulses), 64'd2);

        // 4. frame_start + line_start at idx 2 of W4
        do_line(1'b0, "t4_w4s0");
        do_line(1'b0, "t4_w4s1");
        cur_k = 5;
        cur_s = 0;
        do_line(1'b1, "t4_frame");
        wait_wf(32'd7, "t4_refill");
        do_line(1'b0, "t4_w5s1");

        // 5. back-to-back lines with the DRBG stalled
        bits_stall = 1'b1;
        @(negedge clk);
        line_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 6) begin
                expect_key($sformatf("t5_key%0d", i));
                if (i == 5) check_eq("t5_no_undr", {63'd0, underrun}, 64'd0);
            end else begin
                check_eq("t5_kvld0", {63'd0, key_valid}, 64'd0);
                check_eq("t5_undr", {63'd0, underrun}, 64'd1);
                check_eq("t5_key_hold", key, last_key);
            end
        end
        line_start = 1'b0;
        bits_stall = 1'b0;
        wait_wf(32'd9, "t5_recover");
        check_eq("t5_undr_sticky", {63'd0, underrun}, 64'd1);

        // 6. enable low during S_WAIT, then reset mid-handshake
        bits_stall = 1'b1;
        for (int i = 0; i < 4; i++) do_line(1'b0, $sformatf("t6_w7_%0d", i));
        wait_bits_req("t6_req1");
        enable = 1'b0;
        tick(3);
        bits_stall = 1'b0;
        wait_wf(32'd10, "t6_cap");
        tick(10);
        check_eq("t6_idle_bits", {63'd0, drbg_next_bits}, 64'd0);
        check_eq("t6_wf_hold", {32'd0, words_fetched}, 64'd10);
        check_eq("t6_seed3", 64'(seed_pulses), 64'd3);
        enable = 1'b1;
        tick(3);
        bits_stall = 1'b1;
        for (int i = 0; i < 4; i++) do_line(1'b0, $sformatf("t6_w8_%0d", i));
        wait_bits_req("t6_req2");
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t6_rst_bits", {63'd0, drbg_next_bits}, 64'd0);
        check_eq("t6_rst_init", {63'd0, drbg_init}, 64'd0);
        check_eq("t6_rst_key", key, 64'd0);
        check_eq("t6_rst_kvld", {63'd0, key_valid}, 64'd0);
        check_eq("t6_rst_undr", {63'd0, underrun}, 64'd0);
        check_eq("t6_rst_wf", {32'd0, words_fetched}, 64'd0);
        bits_stall = 1'b0;
        tick(2);
        reset_n = 1'b1;
        wait_wf(32'd2, "t6_refetch");
        check_eq("t6_reinit", 64'(init_pulses), 64'd2);
        cur_k = 10;
        cur_s = 0;
        do_line(1'b0, "t6_key_after");
        check_eq("proto", 64'(proto_viol), 64'd0);
        check_eq("seed_width", 64'(seed_wide), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
